scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Upstream channel-scan controller for the 3-to-8 one-hot decoder stage. On command it steps a 3-bit channel index through the enabled channels of an 8-bit mask, holding each index for a programmable dwell time, and wraps continuously until stopped. `sel` drives the decoder input directly. The status outputs let the controlling logic track channel advances and completed frames.

## Interface
Parameters:
- `DWELL_W`, default 8: width of the dwell-count input and the internal dwell counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin scanning; sampled only in IDLE.
- `stop`, input, 1: end scanning; wins over `start` in the same cycle.
- `dwell`, input, `DWELL_W`: hold time per channel, in cycles minus one. Latched on an accepted `start`.
- `mask`, input, 8: channel-enable bits, where bit i enables channel i. Latched on an accepted `start`.
- `sel`, output, 3: current channel index, feeding the decoder `in`.
- `sel_valid`, output, 1: high while `sel` is a live scan index.
- `step`, output, 1: one-cycle pulse in the first cycle of each new `sel` after an advance.
- `frame_done`, output, 1: one-cycle pulse when the scan wraps back to the lowest enabled channel.
- `busy`, output, 1: high in SCAN.

## Operation
- Reset values: `sel`=0, `sel_valid`=0, `step`=0, `frame_done`=0, `busy`=0. Internal state: IDLE, counter 0, latched mask 0, latched dwell 0. Reset asserted mid-scan forces these values immediately; no pulse is emitted.
- States: IDLE and SCAN.
- IDLE → SCAN:
  - Condition: `start`=1, `stop`=0, `mask`≠0.
  - Actions: latch `mask` and `dwell`; load `sel` with the lowest set bit index of `mask`; clear the counter; set `sel_valid`=1 and `busy`=1.
  - Entry does not pulse `step`.
- IDLE with `start`=1 and `mask`=0: stay in IDLE, with no output change.
- SCAN, per cycle:
  - If the counter ≠ latched dwell, the counter increments.
  - If the counter = latched dwell, the counter clears and `sel` advances to the next set bit of the latched mask strictly above the current `sel`.
  - If no such bit exists, `sel` wraps to the lowest set bit.
  - `step` pulses on every advance. `frame_done` also pulses when the advance wraps.
- Dwell arithmetic: each channel is held for exactly `dwell`+1 cycles. `dwell`=0 gives a new index every cycle. The counter is unsigned `DWELL_W` bits and never overflows, because the comparison is equality against the latched value.
- Single enabled channel: `sel` stays constant. `step` and `frame_done` both pulse every `dwell`+1 cycles.
- SCAN → IDLE on `stop`=1:
  - Next edge gives `sel`=0, `sel_valid`=0, `busy`=0, `step`=0, `frame_done`=0, counter 0.
  - Any advance that would have happened on that edge is suppressed.
- `start` in SCAN is ignored. Changes to `mask` or `dwell` in SCAN have no effect until the next accepted `start`.
- Same-cycle `start` and `stop` in IDLE: stay in IDLE.
- All outputs are registered; there is no combinational path from input to output.

## Timing
- `start` sampled at edge N: `sel`, `sel_valid` and `busy` are valid after edge N (latency 1).
- The first advance lands after edge N+`dwell`+1.
- `step` and `frame_done` are high for exactly the one cycle in which the new `sel` first appears, aligned with `sel`.
- `stop` sampled at edge M: outputs read idle after edge M.
- A new `start` is accepted at edge M+1 at the earliest.
- Decoder output, downstream, is one-hot of `sel` in the same cycle. This block adds no further delay.

## Test plan
- Basic scan:
  - Stimulus: `mask`=8'hA5, `dwell`=2, `start` pulse.
  - Response: from the cycle after `start`, `sel` runs 0,0,0,2,2,2,5,5,5,7,7,7,0,0,0…
  - `step` is high in the first cycle of each 2, 5, 7 and 0. `frame_done` is high only in the first cycle of each return to 0.
- Single channel, minimum dwell:
  - Stimulus: `mask`=8'h10, `dwell`=0.
  - Response: `sel`=4 constant, `sel_valid`=1, and `step` plus `frame_done` are high every cycle after the first scan cycle.
- Stop mid-dwell:
  - Stimulus: `mask`=8'hFF, `dwell`=3, assert `stop` on the second cycle of `sel`=1.
  - Response: on the next cycle, `sel`=0, `sel_valid`=0, `busy`=0, with no `step`.
  - Restart then begins at 0 with a full dwell.
- Rejected and conflicting commands:
  - `start` with `mask`=0: `busy` stays 0.
  - `start` and `stop` in the same IDLE cycle: stays IDLE.
  - `start` during SCAN with a new mask of 8'h01: the sequence is unchanged.
- Async reset mid-scan:
  - Stimulus: assert `rst` between edges while `sel`=5.
  - Response: all outputs 0 before the next edge. After release, the block is IDLE until the next `start`.
- Wide dwell:
  - Stimulus: `DWELL_W`=8, `dwell`=8'hFF, `mask`=8'h03.
  - Response: `sel`=0 for 256 cycles, then 1 for 256 cycles, then `frame_done` as `sel` returns to 0.

Source files
------------

// File: rtl/scan_sequencer.sv
// Channel-scan controller: steps a 3-bit index through the enabled bits of a latched
// 8-bit mask, holding each index for dwell+1 cycles, and wraps until stopped.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               step,
    output logic               frame_done,
    output logic               busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic [2:0]         sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               step_q, step_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;

    // Descending search so the lowest qualifying index is the one left standing.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) begin
                res = {1'b1, 3'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [3:0] nxt_s;
    assign nxt_s = next_above(mask_q, sel_q);

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dwell_d      = dwell_q;
        mask_d       = mask_q;
        sel_d        = sel_q;
        sel_valid_d  = sel_valid_q;
        busy_d       = busy_q;
        step_d       = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (mask != 8'h00)) begin
                    state_d     = ST_SCAN;
                    mask_d      = mask;
                    dwell_d     = dwell;
                    sel_d       = lowest_set(mask);
                    cnt_d       = '0;
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    state_d     = ST_IDLE;
                    sel_d       = 3'd0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                end else if (cnt_q != dwell_q) begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end else begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                    if (nxt_s[3]) begin
                        sel_d = nxt_s[2:0];
                    end else begin
                        sel_d        = lowest_set(mask_q);
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sel_d       = 3'd0;
                sel_valid_d = 1'b0;
                busy_d      = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dwell_q      <= '0;
            mask_q       <= 8'h00;
            sel_q        <= 3'd0;
            sel_valid_q  <= 1'b0;
            step_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            mask_q       <= mask_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
            step_q       <= step_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign step       = step_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer; inputs driven and outputs sampled
// on the falling edge.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       sel_valid;
    logic       step;
    logic       frame_done;
    logic       busy;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .dwell      (dwell),
        .mask       (mask),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .step       (step),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [2:0] basic_sel [15] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5,
                                   3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mask = 8'h00; dwell = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_valid", sel_valid, 0);
        chk("rst_step", step, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic scan, with an ignored start/new mask during SCAN
        mask = 8'hA5; dwell = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("basic_sel", sel, basic_sel[i]);
            chk("basic_step", step, (i > 0 && i % 3 == 0) ? 1 : 0);
            chk("basic_fd", frame_done, (i == 12) ? 1 : 0);
            chk("basic_busy", busy, 1);
            if (i == 1) begin
                start = 1'b1; mask = 8'h01; dwell = 8'd0;
            end else if (i == 2) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop1_sel", sel, 0);
        chk("stop1_valid", sel_valid, 0);
        chk("stop1_busy", busy, 0);
        chk("stop1_step", step, 0);

        // Single channel, dwell 0
        mask = 8'h10; dwell = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("single_sel", sel, 4);
            chk("single_valid", sel_valid, 1);
            chk("single_step", step, (i > 0) ? 1 : 0);
            chk("single_fd", frame_done, (i > 0) ? 1 : 0);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Stop on second cycle of sel=1, then restart
        mask = 8'hFF; dwell = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("mid_sel", sel, (i < 4) ? 0 : 1);
            if (i == 5) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        chk("mid_stop_sel", sel, 0);
        chk("mid_stop_valid", sel_valid, 0);
        chk("mid_stop_busy", busy, 0);
        chk("mid_stop_step", step, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("restart_sel", sel, (i < 4) ? 0 : 1);
            chk("restart_step", step, (i == 4) ? 1 : 0);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Rejected / conflicting commands
        mask = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_mask_busy", busy, 0);
        chk("zero_mask_valid", sel_valid, 0);
        mask = 8'h01; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", busy, 0);
        @(negedge clk);
        chk("start_stop_busy2", busy, 0);

        // Asynchronous reset while sel=5
        mask = 8'hA5; dwell = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_sel", sel, 5);
        chk("pre_rst_step", step, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_valid", sel_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_step", step, 0);
        chk("arst_fd", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", sel_valid, 0);

        // Wide dwell
        mask = 8'h03; dwell = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 512; i++) begin
            if (i == 0 || i == 255) begin
                chk("wide_sel0", sel, 0);
                chk("wide_step0", step, 0);
            end else if (i == 256) begin
                chk("wide_sel1", sel, 1);
                chk("wide_step1", step, 1);
                chk("wide_fd1", frame_done, 0);
            end else if (i == 511) begin
                chk("wide_sel1_end", sel, 1);
                chk("wide_step_end", step, 0);
            end else if (i == 512) begin
                chk("wide_wrap_sel", sel, 0);
                chk("wide_wrap_step", step, 1);
                chk("wide_wrap_fd", frame_done, 1);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
